// File: rtl/cache_tag_bank_nway_if.sv
// Request/response bus of the N-way cache tag bank.
// The master issues requests; the tag bank (slave) answers one cycle after accepting.
interface cache_tag_bank_nway_if #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 1024,
  parameter int unsigned TAG_W = 11
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [IDX_W-1:0] req_index;
  logic [TAG_W-1:0] req_tag;
  logic             req_write;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic             rsp_evict;
  logic [TAG_W-1:0] rsp_evict_tag;
  logic             rsp_evict_dirty;

  modport master (
    output req_valid, req_op, req_index, req_tag, req_write,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, rsp_evict_dirty
  );

  modport slave (
    input  req_valid, req_op, req_index, req_tag, req_write,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag, rsp_evict_dirty
  );
endinterface

// File: rtl/cache_tag_bank_nway.sv
// N-way set-associative tag bank: tag/valid/dirty per way and true-LRU ages per set.
// Lookup, fill with victim selection, and line invalidate; clears itself after reset or flush.
module cache_tag_bank_nway #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned SETS  = 1024,
  parameter int unsigned TAG_W = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic                 busy,
  cache_tag_bank_nway_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {ST_CLR, ST_IDLE, ST_EXEC} state_t;

  state_t state;
  logic [IDX_W-1:0] clr_idx;
  logic [IDX_W-1:0] idx_q;

  logic [WAYS-1:0][TAG_W-1:0] tag_mem   [SETS];
  logic [WAYS-1:0]            valid_mem [SETS];
  logic [WAYS-1:0]            dirty_mem [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_mem   [SETS];

  logic [WAYS-1:0][TAG_W-1:0] rd_tag,   nxt_tag,   wb_tag;
  logic [WAYS-1:0]            rd_valid, nxt_valid, wb_valid;
  logic [WAYS-1:0]            rd_dirty, nxt_dirty, wb_dirty;
  logic [WAYS-1:0][WAY_W-1:0] rd_age,   nxt_age,   wb_age;

  logic             hit, inv_found, touch, is_fill, is_inval;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim, touch_way;
  logic             r_way_unused;
  logic [WAY_W-1:0] r_way;
  logic             r_evict, r_evict_dirty;
  logic [TAG_W-1:0] r_evict_tag;

  assign rd_tag   = tag_mem[bus.req_index];
  assign rd_valid = valid_mem[bus.req_index];
  assign rd_dirty = dirty_mem[bus.req_index];
  assign rd_age   = age_mem[bus.req_index];

  assign bus.req_ready = (state == ST_IDLE) && !flush;
  assign r_way_unused  = 1'b0;

  // Compare the addressed set and build both the response and the updated set contents.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_tag[w] == bus.req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!rd_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (rd_age[w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end

    is_fill       = (bus.req_op == 2'b01);
    is_inval      = (bus.req_op == 2'b10);
    victim        = inv_found ? inv_way : lru_way;
    nxt_tag       = rd_tag;
    nxt_valid     = rd_valid;
    nxt_dirty     = rd_dirty;
    nxt_age       = rd_age;
    touch         = 1'b0;
    touch_way     = hit_way;
    r_way         = '0;
    r_evict       = 1'b0;
    r_evict_tag   = '0;
    r_evict_dirty = 1'b0;

    if (hit) begin
      r_way = hit_way;
      if (is_inval) begin
        nxt_valid[hit_way] = 1'b0;
        nxt_dirty[hit_way] = 1'b0;
        r_evict_dirty      = rd_dirty[hit_way];
      end else begin
        nxt_dirty[hit_way] = rd_dirty[hit_way] | bus.req_write;
        touch              = 1'b1;
      end
    end else if (is_fill) begin
      r_way             = victim;
      r_evict           = rd_valid[victim];
      r_evict_tag       = rd_tag[victim];
      r_evict_dirty     = rd_dirty[victim];
      nxt_tag[victim]   = bus.req_tag;
      nxt_valid[victim] = 1'b1;
      nxt_dirty[victim] = bus.req_write;
      touch             = 1'b1;
      touch_way         = victim;
    end

    // True-LRU touch: younger ways age by one, the touched way becomes youngest.
    if (touch) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (WAY_W'(w) == touch_way)              nxt_age[w] = '0;
        else if (rd_age[w] < rd_age[touch_way])  nxt_age[w] = rd_age[w] + WAY_W'(1);
      end
    end
  end

  // Control FSM with registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_CLR;
      clr_idx             <= '0;
      busy                <= 1'b1;
      idx_q               <= '0;
      wb_tag              <= '0;
      wb_valid            <= '0;
      wb_dirty            <= '0;
      wb_age              <= '0;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_hit         <= 1'b0;
      bus.rsp_way         <= '0;
      bus.rsp_evict       <= 1'b0;
      bus.rsp_evict_tag   <= '0;
      bus.rsp_evict_dirty <= 1'b0;
    end else begin
      case (state)
        ST_CLR: begin
          clr_idx <= clr_idx + IDX_W'(1);
          if (clr_idx == IDX_W'(SETS - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (flush) begin
            state   <= ST_CLR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end else if (bus.req_valid) begin
            state               <= ST_EXEC;
            idx_q               <= bus.req_index;
            wb_tag              <= nxt_tag;
            wb_valid            <= nxt_valid;
            wb_dirty            <= nxt_dirty;
            wb_age              <= nxt_age;
            bus.rsp_valid       <= 1'b1;
            bus.rsp_hit         <= hit;
            bus.rsp_way         <= r_way;
            bus.rsp_evict       <= r_evict | r_way_unused;
            bus.rsp_evict_tag   <= r_evict_tag;
            bus.rsp_evict_dirty <= r_evict_dirty;
          end
        end
        ST_EXEC: begin
          state         <= ST_IDLE;
          bus.rsp_valid <= 1'b0;
        end
        default: begin
          state   <= ST_CLR;
          clr_idx <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Set arrays: cleared one set per cycle while sweeping, written back at the end of EXEC.
  always_ff @(posedge clk) begin
    if (state == ST_CLR) begin
      valid_mem[clr_idx] <= '0;
      dirty_mem[clr_idx] <= '0;
      for (int w = 0; w < int'(WAYS); w++) age_mem[clr_idx][w] <= WAY_W'(w);
    end else if (state == ST_EXEC) begin
      tag_mem[idx_q]   <= wb_tag;
      valid_mem[idx_q] <= wb_valid;
      dirty_mem[idx_q] <= wb_dirty;
      age_mem[idx_q]   <= wb_age;
    end
  end
endmodule

// File: tb/tb_cache_tag_bank_nway.sv
// Bench for cache_tag_bank_nway: directed vector table, flush/reset corner sequences,
// and random traffic checked against a recency-list model of the tag bank.
module tb_cache_tag_bank_nway;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned SETS  = 1024;
  localparam int unsigned TAG_W = 11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  cache_tag_bank_nway_if #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) bus ();

  cache_tag_bank_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: per-set line state plus a recency list (index 0 = most recent, last = LRU).
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int order   [SETS][WAYS];

  typedef struct {
    logic [1:0] op;
    int         tag;
    bit         wr;
    bit         e_hit;
    int         e_way;
    bit         cw;
    bit         e_ev;
    int         e_evt;
    bit         e_evd;
    bit         cd;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < int'(SETS); s++)
      for (int w = 0; w < int'(WAYS); w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        order[s][w]   = w;
      end
  endfunction

  function automatic void touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < int'(WAYS); i++) if (order[s][i] == w) p = i;
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = w;
  endfunction

  function automatic void model_op(input logic [1:0] op, input int s, input int tg, input bit wr,
                                   output bit e_hit, output int e_way, output bit e_ev,
                                   output int e_evt, output bit e_evd, output bit cw, output bit cd);
    int hw = -1;
    int v  = -1;
    for (int w = 0; w < int'(WAYS); w++)
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    e_hit = (hw >= 0); e_way = 0; e_ev = 0; e_evt = 0; e_evd = 0; cw = 0; cd = 0;
    if (op == 2'b10) begin
      if (hw >= 0) begin
        e_way = hw; cw = 1; cd = 1; e_evd = m_dirty[s][hw];
        m_valid[s][hw] = 1'b0;
        m_dirty[s][hw] = 1'b0;
      end
    end else if (hw >= 0) begin
      e_way = hw; cw = 1;
      m_dirty[s][hw] = m_dirty[s][hw] | wr;
      touch(s, hw);
    end else if (op == 2'b01) begin
      for (int w = 0; w < int'(WAYS); w++) if (v < 0 && !m_valid[s][w]) v = w;
      if (v < 0) v = order[s][WAYS-1];
      e_way = v; cw = 1;
      e_ev  = m_valid[s][v];
      if (e_ev) begin
        e_evt = m_tag[s][v]; e_evd = m_dirty[s][v]; cd = 1;
      end
      m_tag[s][v] = tg; m_valid[s][v] = 1'b1; m_dirty[s][v] = wr;
      touch(s, v);
    end
  endfunction

  // One request: wait for ready (bounded), accept, sample the response in the following cycle.
  task automatic do_req(input logic [1:0] op, input int idx, input int tg, input bit wr,
                        output bit g_hit, output int g_way, output bit g_ev,
                        output int g_evt, output bit g_evd);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_index = 10'(idx);
    bus.req_tag   = 11'(tg);
    bus.req_write = wr;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    g_hit = bus.rsp_hit;
    g_way = int'(bus.rsp_way);
    g_ev  = bus.rsp_evict;
    g_evt = int'(bus.rsp_evict_tag);
    g_evd = bus.rsp_evict_dirty;
    @(posedge clk);
    #1;
    chk("rsp_valid_one_cycle", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_rsp(input string nm, input bit g_hit, input int g_way, input bit g_ev,
                           input int g_evt, input bit g_evd, input bit e_hit, input int e_way,
                           input bit cw, input bit e_ev, input int e_evt, input bit e_evd, input bit cd);
    chk({nm, ".hit"}, 32'(g_hit), 32'(e_hit));
    if (cw)   chk({nm, ".way"}, 32'(g_way), 32'(e_way));
    chk({nm, ".evict"}, 32'(g_ev), 32'(e_ev));
    if (e_ev) chk({nm, ".evict_tag"}, 32'(g_evt), 32'(e_evt));
    if (cd)   chk({nm, ".evict_dirty"}, 32'(g_evd), 32'(e_evd));
  endtask

  task automatic run_model(input string nm, input logic [1:0] op, input int idx, input int tg, input bit wr);
    bit g_hit, g_ev, g_evd, e_hit, e_ev, e_evd, cw, cd;
    int g_way, g_evt, e_way, e_evt;
    do_req(op, idx, tg, wr, g_hit, g_way, g_ev, g_evt, g_evd);
    model_op(op, idx, tg, wr, e_hit, e_way, e_ev, e_evt, e_evd, cw, cd);
    check_rsp(nm, g_hit, g_way, g_ev, g_evt, g_evd, e_hit, e_way, cw, e_ev, e_evt, e_evd, cd);
  endtask

  // Count cycles with busy high; req_ready or rsp_valid during the sweep is an error.
  task automatic wait_idle(output int cyc, output int bad);
    cyc = 0;
    bad = 0;
    while (busy && cyc < 3000) begin
      if (bus.req_ready || bus.rsp_valid) bad++;
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int tg, input bit wr, input bit h, input int w,
                              input bit cw, input bit ev, input int evt, input bit evd, input bit cd);
    vec_t v;
    v.op = op; v.tag = tg; v.wr = wr; v.e_hit = h; v.e_way = w; v.cw = cw;
    v.e_ev = ev; v.e_evt = evt; v.e_evd = evd; v.cd = cd;
    return v;
  endfunction

  initial begin
    int cyc, bad, idx;
    bit g_hit, g_ev, g_evd, e_hit, e_ev, e_evd, cw, cd;
    int g_way, g_evt, e_way, e_evt;

    vt[0]  = mk(2'b00, 'h123, 0, 0, 0, 0, 0, 0,     0, 0);
    vt[1]  = mk(2'b01, 'h001, 0, 0, 0, 1, 0, 0,     0, 0);
    vt[2]  = mk(2'b01, 'h002, 0, 0, 1, 1, 0, 0,     0, 0);
    vt[3]  = mk(2'b01, 'h003, 0, 0, 2, 1, 0, 0,     0, 0);
    vt[4]  = mk(2'b01, 'h004, 0, 0, 3, 1, 0, 0,     0, 0);
    vt[5]  = mk(2'b00, 'h003, 0, 1, 2, 1, 0, 0,     0, 0);
    vt[6]  = mk(2'b00, 'h001, 0, 1, 0, 1, 0, 0,     0, 0);
    vt[7]  = mk(2'b00, 'h003, 0, 1, 2, 1, 0, 0,     0, 0);
    vt[8]  = mk(2'b01, 'h005, 1, 0, 1, 1, 1, 'h002, 0, 1);
    vt[9]  = mk(2'b00, 'h005, 1, 1, 1, 1, 0, 0,     0, 0);
    vt[10] = mk(2'b10, 'h005, 0, 1, 1, 1, 0, 0,     1, 1);
    vt[11] = mk(2'b00, 'h005, 0, 0, 0, 0, 0, 0,     0, 0);
    vt[12] = mk(2'b01, 'h004, 1, 1, 3, 1, 0, 0,     0, 0);
    vt[13] = mk(2'b11, 'h004, 0, 1, 3, 1, 0, 0,     0, 0);
    vt[14] = mk(2'b01, 'h006, 0, 0, 1, 1, 0, 0,     0, 0);
    vt[15] = mk(2'b01, 'h007, 0, 0, 0, 1, 1, 'h001, 0, 1);
    vt[16] = mk(2'b01, 'h008, 0, 0, 2, 1, 1, 'h003, 0, 1);
    vt[17] = mk(2'b01, 'h009, 0, 0, 3, 1, 1, 'h004, 1, 1);

    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_index = '0;
    bus.req_tag   = '0;
    bus.req_write = 1'b0;
    model_clear();

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset.busy",        32'(busy),                32'd1);
    chk("reset.req_ready",   32'(bus.req_ready),       32'd0);
    chk("reset.rsp_valid",   32'(bus.rsp_valid),       32'd0);
    chk("reset.rsp_hit",     32'(bus.rsp_hit),         32'd0);
    chk("reset.rsp_way",     32'(bus.rsp_way),         32'd0);
    chk("reset.rsp_evict",   32'(bus.rsp_evict),       32'd0);
    chk("reset.evict_tag",   32'(bus.rsp_evict_tag),   32'd0);
    chk("reset.evict_dirty", 32'(bus.rsp_evict_dirty), 32'd0);

    // Release reset with a fill pending: it must not be accepted during the sweep.
    rst_n = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_index = 10'd5;
    bus.req_tag   = 11'h7ff;
    wait_idle(cyc, bad);
    bus.req_valid = 1'b0;
    chk("init.busy_cycles", 32'(cyc), 32'(SETS));
    chk("init.busy_handshake", 32'(bad), 32'd0);

    // Directed sequence on set 5.
    for (int i = 0; i < 18; i++) begin
      do_req(vt[i].op, 5, vt[i].tag, vt[i].wr, g_hit, g_way, g_ev, g_evt, g_evd);
      model_op(vt[i].op, 5, vt[i].tag, vt[i].wr, e_hit, e_way, e_ev, e_evt, e_evd, cw, cd);
      check_rsp($sformatf("vec%0d", i), g_hit, g_way, g_ev, g_evt, g_evd,
                vt[i].e_hit, vt[i].e_way, vt[i].cw, vt[i].e_ev, vt[i].e_evt, vt[i].e_evd, vt[i].cd);
    end

    // Flush wins over a simultaneous request.
    @(negedge clk);
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_index = 10'd5;
    bus.req_tag   = 11'h00a;
    #1;
    chk("flush.req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("flush.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("flush.busy",      32'(busy),          32'd1);
    @(negedge clk);
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    wait_idle(cyc, bad);
    chk("flush.busy_cycles", 32'(cyc), 32'(SETS));
    chk("flush.busy_handshake", 32'(bad), 32'd0);
    model_clear();
    run_model("postflush0", 2'b00, 5, 'h009, 0);
    run_model("postflush1", 2'b00, 5, 'h006, 0);
    run_model("postflush2", 2'b10, 5, 'h007, 0);
    run_model("postflush3", 2'b00, 5, 'h00a, 0);

    // Reset asserted while a response is being driven.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_index = 10'd9;
    bus.req_tag   = 11'h055;
    bus.req_write = 1'b1;
    @(posedge clk);
    #1;
    chk("rstexec.accepted", 32'(bus.rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstexec.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rstexec.busy",      32'(busy),          32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(cyc, bad);
    chk("rstexec.busy_cycles", 32'(cyc), 32'(SETS));
    model_clear();
    run_model("rstexec.lookup", 2'b00, 9, 'h055, 0);

    // Random traffic on a few sets with a small tag pool to force hits and evictions.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       idx = 0;
        1:       idx = 1;
        2:       idx = 2;
        default: idx = int'(SETS) - 1;
      endcase
      run_model($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), idx,
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
